// File: rtl/hex_entry_display.sv
// Display side of the digit-entry interface: blinks the digit under entry, keeps user history,
// masks password digits and shows OPEN on grant. Outputs are registered and reflect inputs one clk later.
module hex_entry_display #(
  parameter int BLINK_HALF = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state_for_decoder,
  input  logic [3:0] output_to_decoder,
  input  logic       access_valid,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);

  localparam logic [3:0] CODE_IDLE  = 4'd0;
  localparam logic [3:0] CODE_USER0 = 4'd5;
  localparam logic [3:0] CODE_USER3 = 4'd8;
  localparam logic [3:0] CODE_PASS0 = 4'd9;
  localparam logic [3:0] CODE_PASS4 = 4'd13;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_UNDER = 7'h77;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_O     = 7'h40;

  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    case (d)
      4'h0: hex_seg = 7'h40;  4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;  4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;  4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;  4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;  4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;  4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;  4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;  default: hex_seg = 7'h0E;
    endcase
  endfunction

  logic [3:0][3:0] hist, hist_n;
  logic [3:0]      hist_vld, hist_vld_n;
  logic [2:0]      pass_count, pass_n;
  logic [3:0]      prev_code;
  logic [CW-1:0]   blink_cnt, blink_cnt_n;
  logic            blink_on, blink_on_n;
  logic            changed;
  logic [1:0]      user_idx;
  logic [6:0]      live_seg;
  logic [3:0][6:0] disp;

  // Next-state values feed the display so a captured digit, a new pass count
  // and a restarted blink all appear on the same edge as the new index.
  always_comb begin
    changed    = (state_for_decoder != prev_code);
    hist_n     = hist;
    hist_vld_n = hist_vld;
    pass_n     = pass_count;
    if (changed) begin
      if (state_for_decoder == CODE_USER0) begin
        hist_n     = '0;
        hist_vld_n = '0;
        pass_n     = '0;
      end else if (state_for_decoder > CODE_USER0 && state_for_decoder <= CODE_USER3 &&
                   prev_code == state_for_decoder - 4'd1) begin
        hist_n[2'(state_for_decoder - 4'd6)]     = output_to_decoder;
        hist_vld_n[2'(state_for_decoder - 4'd6)] = 1'b1;
      end else if (state_for_decoder == CODE_PASS0) begin
        pass_n = '0;
      end else if (state_for_decoder > CODE_PASS0 && state_for_decoder <= CODE_PASS4 &&
                   prev_code == state_for_decoder - 4'd1) begin
        pass_n = pass_count + 3'd1;
      end
    end
  end

  always_comb begin
    if (changed) begin
      blink_cnt_n = '0;
      blink_on_n  = 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_n = '0;
      blink_on_n  = ~blink_on;
    end else begin
      blink_cnt_n = blink_cnt + CW'(1);
      blink_on_n  = blink_on;
    end
  end

  // disp[k] drives hex k; user index j lands on display 3-j.
  always_comb begin
    disp     = {4{SEG_BLANK}};
    user_idx = 2'(state_for_decoder - CODE_USER0);
    live_seg = blink_on_n ? hex_seg(output_to_decoder) : SEG_BLANK;
    if (state_for_decoder == CODE_IDLE) begin
      if (access_valid) disp = {SEG_O, SEG_P, SEG_E, SEG_N};
    end else if (state_for_decoder >= CODE_USER0 && state_for_decoder <= CODE_USER3) begin
      for (int j = 0; j < 4; j++) begin
        if (j < int'(user_idx))
          disp[3-j] = hist_vld_n[j] ? hex_seg(hist_n[j]) : SEG_UNDER;
        else if (j == int'(user_idx))
          disp[3-j] = live_seg;
        else
          disp[3-j] = SEG_UNDER;
      end
    end else if (state_for_decoder >= CODE_PASS0 && state_for_decoder <= CODE_PASS4) begin
      disp[3] = SEG_P;
      disp[2] = hex_seg({1'b0, pass_n});
      disp[1] = (pass_n != 3'd0) ? SEG_DASH : SEG_BLANK;
      disp[0] = live_seg;
    end else begin
      disp[3] = SEG_E;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist       <= '0;
      hist_vld   <= '0;
      pass_count <= '0;
      prev_code  <= '0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
      hex0       <= SEG_BLANK;
      hex1       <= SEG_BLANK;
      hex2       <= SEG_BLANK;
      hex3       <= SEG_BLANK;
    end else begin
      hist       <= hist_n;
      hist_vld   <= hist_vld_n;
      pass_count <= pass_n;
      prev_code  <= state_for_decoder;
      blink_cnt  <= blink_cnt_n;
      blink_on   <= blink_on_n;
      hex0       <= disp[0];
      hex1       <= disp[1];
      hex2       <= disp[2];
      hex3       <= disp[3];
    end
  end

endmodule

// File: tb/tb_hex_entry_display.sv
// Directed bench for hex_entry_display with a short blink period.
module tb_hex_entry_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] state_for_decoder = 4'd0;
  logic [3:0] output_to_decoder = 4'd0;
  logic       access_valid = 1'b0;
  logic [6:0] hex0, hex1, hex2, hex3;

  int tests = 0;
  int fails = 0;

  hex_entry_display #(.BLINK_HALF(4)) dut (
    .clk(clk), .rst(rst),
    .state_for_decoder(state_for_decoder),
    .output_to_decoder(output_to_decoder),
    .access_valid(access_valid),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [6:0] e3, e2, e1, e0);
    chk({tag, ".hex3"}, hex3, e3);
    chk({tag, ".hex2"}, hex2, e2);
    chk({tag, ".hex1"}, hex1, e1);
    chk({tag, ".hex0"}, hex0, e0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tick(2);
    chk4("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    rst = 1'b0;

    // First user digit and blink cadence
    state_for_decoder = 4'd5; output_to_decoder = 4'd1;
    tick();
    chk4("user0", 7'h79, 7'h77, 7'h77, 7'h77);
    tick(3);
    chk("blink_on_last", hex3, 7'h79);
    tick();
    chk("blink_off", hex3, 7'h7F);
    tick(3);
    chk("blink_off_last", hex3, 7'h7F);
    tick();
    chk("blink_on_again", hex3, 7'h79);
    tick(4);
    chk("blink_off_pre_step", hex3, 7'h7F);

    // Steps capture history; blink restart shows live digit at once
    state_for_decoder = 4'd6;
    tick();
    chk4("user1", 7'h79, 7'h79, 7'h77, 7'h77);
    state_for_decoder = 4'd7;
    tick();
    chk4("user2", 7'h79, 7'h79, 7'h79, 7'h77);
    output_to_decoder = 4'd2;
    tick();
    chk("user2_live", hex1, 7'h24);
    state_for_decoder = 4'd8;
    tick();
    chk4("user3", 7'h79, 7'h79, 7'h24, 7'h24);
    output_to_decoder = 4'd7;
    tick();
    chk("user3_live", hex0, 7'h78);
    tick(3);
    chk("user3_blink_off", hex0, 7'h7F);

    // Password entry
    state_for_decoder = 4'd9;
    tick();
    chk4("pass0", 7'h0C, 7'h40, 7'h7F, 7'h78);
    state_for_decoder = 4'd10; output_to_decoder = 4'd2;
    tick();
    chk4("pass1", 7'h0C, 7'h79, 7'h3F, 7'h24);
    state_for_decoder = 4'd11; output_to_decoder = 4'd1;
    tick();
    state_for_decoder = 4'd12;
    tick();
    chk("pass3.hex2", hex2, 7'h30);
    state_for_decoder = 4'd13; output_to_decoder = 4'hA;
    tick();
    chk4("pass4", 7'h0C, 7'h19, 7'h3F, 7'h08);
    tick(4);
    chk("pass4_blink_off", hex0, 7'h7F);
    state_for_decoder = 4'd9;
    tick();
    chk4("retry", 7'h0C, 7'h40, 7'h7F, 7'h08);

    // Grant
    state_for_decoder = 4'd0; access_valid = 1'b1;
    tick();
    chk4("open", 7'h40, 7'h0C, 7'h06, 7'h2B);
    access_valid = 1'b0;
    tick();
    chk4("idle_blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // Illegal codes ignore access_valid
    state_for_decoder = 4'd3; access_valid = 1'b1;
    tick();
    chk4("illegal3", 7'h06, 7'h7F, 7'h7F, 7'h7F);
    access_valid = 1'b0;
    state_for_decoder = 4'd14;
    tick();
    chk4("illegal14", 7'h06, 7'h7F, 7'h7F, 7'h7F);

    // Async reset mid-entry wipes history
    state_for_decoder = 4'd5; output_to_decoder = 4'd9;
    tick();
    state_for_decoder = 4'd6;
    tick();
    output_to_decoder = 4'd4;
    tick();
    state_for_decoder = 4'd7;
    tick();
    chk4("pre_reset", 7'h10, 7'h19, 7'h19, 7'h77);
    #2 rst = 1'b1;
    #1;
    chk4("async_reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    #1 rst = 1'b0;
    state_for_decoder = 4'd6; output_to_decoder = 4'd3;
    tick();
    chk4("no_capture", 7'h77, 7'h30, 7'h77, 7'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
